mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, in the EX stage of the pipelined MIPS core.
- Consumes the two register-file read operands (rs → A, rt → B) and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Exposes HI/LO to the MFHI/MFLO datapath mux.
- Drives Busy so the hazard logic can stall any following HI/LO-touching instruction in ID.

Parameters:
- MULT_CYCLES, 5, Busy duration of MULT/MULTU in cycles (legal range ≥1).
- DIV_CYCLES, 10, Busy duration of DIV/DIVU in cycles (legal range ≥1).

Ports:
- Clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clock Clk.
- Start  input  1  issue strobe for MDOp this cycle.
- MDOp  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- A  input  32  operand rs (dividend / multiplicand / MTHI-MTLO data).
- B  input  32  operand rt (divisor / multiplier).
- Flush  input  1  abort an in-flight operation (exception/branch squash).
- Busy  output  1  operation in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (async, any time, including mid-operation):
  - HI=0, LO=0, Busy=0, counter=0, result latches=0.
  - Pending operation discarded.
- Issue accepted at a posedge where Start=1, Busy=0, Flush=0:
  - Start with Busy=1 is ignored; upstream must hold/stall.
  - MTHI: HI<=A at that edge; Busy stays 0; LO unchanged.
  - MTLO: LO<=A at that edge; Busy stays 0; HI unchanged.
  - MULT/MULTU/DIV/DIVU: A, B and op are latched. Counter <= MULT_CYCLES or DIV_CYCLES. Busy=1 from that edge.
  - Opcodes 110/111: no state change.
- Counting:
  - Each posedge with Busy=1 and Flush=0 decrements the counter.
  - At the edge where counter==1: HI/LO committed, counter<=0, Busy<=0.
  - Busy is therefore high for exactly N cycles. New HI/LO are visible after edge t+N, where t is the issue edge.
  - A new Start is accepted at edge t+N+1 at the earliest. This is the first edge at which Busy=0 is sampled.
- Arithmetic (computed from latched operands; the result may be formed iteratively or combinationally, provided the commit timing above holds):
  - MULT: 64-bit two's-complement product of A×B; HI=bits 63:32, LO=bits 31:0.
  - MULTU: same, both operands unsigned.
  - DIV: LO=quotient truncated toward zero; HI=remainder, sign of dividend (|HI|<|B|).
  - DIV, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - DIVU: unsigned quotient → LO, remainder → HI.
  - DIV/DIVU with B=0: full DIV_CYCLES Busy, HI and LO left unchanged at commit.
- Flush:
  - With Busy=1: the next edge clears Busy and the counter; HI/LO unchanged (no partial commit), even if counter==1 on that edge.
  - With Busy=0: Start is ignored that cycle, including MTHI/MTLO.
  - Flush and Start together: Flush wins.
- HI and LO are driven directly from registers; there is no combinational bypass of an in-flight result.
- Operand changes on A/B after issue have no effect.

Test Plan:
- Reset mid-DIV (assert reset at cycle 4 of 10) → Busy=0, HI=0, LO=0 immediately; next Start MTLO A=0x1234 → LO=0x00001234 after one edge, Busy never rises.
- MULT A=0xFFFFFFFE, B=3 → Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (−7), B=2 → after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 → LO=3, HI=1.
- DIVU A=7, B=0, with HI=0xAA, LO=0xBB preloaded via MTHI/MTLO → Busy 10 cycles; HI=0xAA, LO=0xBB afterwards. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MULT issued, Start MTHI A=0x55 on cycle 2 while Busy → ignored: HI reflects the MULT result only. Start on the cycle Busy first samples 0 → accepted.
- MULT issued, Flush at cycle 5 (counter==1) together with Start=1 → Busy=0 next edge; HI/LO unchanged; no new op started.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// An operation latches its operands at issue and commits HI/LO after a
// fixed number of Busy cycles; MTHI/MTLO write directly in one edge.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Flush,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    typedef enum logic [1:0] {
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU
    } mdop_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    mdop_t          op_q, op_d;
    logic [31:0]    a_q, a_d;
    logic [31:0]    b_q, b_d;
    logic [31:0]    hi_q, hi_d;
    logic [31:0]    lo_q, lo_d;

    logic           is_signed;
    logic [63:0]    a_ext, b_ext, prod;
    logic           a_neg, b_neg;
    logic [31:0]    a_mag, b_mag, b_div;
    logic [31:0]    uquo, urem;
    logic [31:0]    res_hi, res_lo;
    logic           res_we;

    // Result datapath from the latched operands; division runs on magnitudes
    // and re-applies signs so 0x80000000 / -1 needs no special case.
    always_comb begin
        is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
        a_ext     = is_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        b_ext     = is_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod      = a_ext * b_ext;

        a_neg     = is_signed & a_q[31];
        b_neg     = is_signed & b_q[31];
        a_mag     = a_neg ? (32'd0 - a_q) : a_q;
        b_mag     = b_neg ? (32'd0 - b_q) : b_q;
        b_div     = (b_mag == 32'd0) ? 32'd1 : b_mag;
        uquo      = a_mag / b_div;
        urem      = a_mag % b_div;

        if ((op_q == OP_MULT) || (op_q == OP_MULTU)) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
            res_we = 1'b1;
        end else begin
            res_hi = a_neg ? (32'd0 - urem) : urem;
            res_lo = (a_neg ^ b_neg) ? (32'd0 - uquo) : uquo;
            res_we = (b_q != 32'd0);
        end
    end

    // Next-state: issue from idle, count down while running, commit or flush.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (Start && !Flush) begin
                    case (MDOp)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            op_d    = mdop_t'(MDOp[1:0]);
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = MDOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                            state_d = S_RUN;
                        end
                        3'b100:  hi_d = A;
                        3'b101:  lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (Flush) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(1)) begin
                    if (res_we) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and architectural registers with asynchronous reset.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy = (state_q == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus randomized
// traffic compared against a behavioural HI/LO model using 64-bit arithmetic.
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic        Clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_cnt;
    logic [31:0] m_hi, m_lo;
    logic [31:0] p_hi, p_lo;
    bit          p_we;

    mult_div_unit #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .Clk  (Clk),
        .reset(reset),
        .Start(Start),
        .MDOp (MDOp),
        .A    (A),
        .B    (B),
        .Flush(Flush),
        .Busy (Busy),
        .HI   (HI),
        .LO   (LO)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_cnt = 0;
        m_hi  = '0;
        m_lo  = '0;
        p_hi  = '0;
        p_lo  = '0;
        p_we  = 1'b0;
    endfunction

    // Architectural result of an operation, computed at issue time.
    function automatic void m_compute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        p_we = 1'b1;
        case (op)
            OP_MULT: begin
                sp = sa * sb;
                r  = sp;
                p_hi = r[63:32];
                p_lo = r[31:0];
            end
            OP_MULTU: begin
                up = ua * ub;
                r  = up;
                p_hi = r[63:32];
                p_lo = r[31:0];
            end
            OP_DIV: begin
                if (b == 32'd0) p_we = 1'b0;
                else begin
                    r    = sa / sb;
                    p_lo = r[31:0];
                    r    = sa % sb;
                    p_hi = r[31:0];
                end
            end
            default: begin
                if (b == 32'd0) p_we = 1'b0;
                else begin
                    r    = ua / ub;
                    p_lo = r[31:0];
                    r    = ua % ub;
                    p_hi = r[31:0];
                end
            end
        endcase
    endfunction

    // One clock edge of architectural behaviour.
    function automatic void m_step(input bit s, input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input bit f);
        if (m_cnt > 0) begin
            if (f) m_cnt = 0;
            else if (m_cnt == 1) begin
                if (p_we) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
                m_cnt = 0;
            end else m_cnt--;
        end else if (s && !f) begin
            if (op[2] == 1'b0) begin
                m_compute(op, a, b);
                m_cnt = op[1] ? DC : MC;
            end else if (op == OP_MTHI) m_hi = a;
            else if (op == OP_MTLO) m_lo = a;
        end
    endfunction

    // Drive one cycle of inputs, advance an edge, compare against the model.
    task automatic cyc(input bit s, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit f);
        Start = s;
        MDOp  = op;
        A     = a;
        B     = b;
        Flush = f;
        @(posedge Clk);
        m_step(s, op, a, b, f);
        #1;
        check("busy", 64'(Busy), 64'(m_cnt > 0));
        check("hi", 64'(HI), 64'(m_hi));
        check("lo", 64'(LO), 64'(m_lo));
    endtask

    task automatic idle();
        cyc(1'b0, 3'b000, $urandom, $urandom, 1'b0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #1;
        reset = 1'b1;
        #1;
        m_reset();
        check("rst_busy", 64'(Busy), 64'(0));
        check("rst_hi", 64'(HI), 64'(0));
        check("rst_lo", 64'(LO), 64'(0));
        #1;
        reset = 1'b0;
    endtask

    // Issue an op, wait for Busy to fall, and check the Busy length.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_len);
        int n;
        int guard;
        n = 0;
        guard = 0;
        cyc(1'b1, op, a, b, 1'b0);
        while (Busy && guard < 50) begin
            n++;
            guard++;
            idle();
        end
        check(tag, 64'(n), 64'(exp_len));
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd0;
            3: return $urandom_range(0, 15);
            4: return 32'd0 - $urandom_range(1, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        Start = 1'b0;
        MDOp  = '0;
        A     = '0;
        B     = '0;
        Flush = 1'b0;
        m_reset();
        repeat (2) @(posedge Clk);
        #1;
        check("init_busy", 64'(Busy), 64'(0));
        check("init_hi", 64'(HI), 64'(0));
        check("init_lo", 64'(LO), 64'(0));
        reset = 1'b0;

        // Reset during a DIV, then MTLO
        cyc(1'b1, OP_MTHI, 32'h0000_00C3, 0, 1'b0);
        cyc(1'b1, OP_DIV, 32'd100, 32'd7, 1'b0);
        repeat (3) idle();
        async_reset();
        cyc(1'b1, OP_MTLO, 32'h0000_1234, 0, 1'b0);
        check("mtlo_val", 64'(LO), 64'h1234);
        check("mtlo_nobusy", 64'(Busy), 64'(0));
        idle();
        check("mtlo_nobusy2", 64'(Busy), 64'(0));

        // Multiply
        run_op("mult_len", OP_MULT, 32'hFFFF_FFFE, 32'd3, MC);
        check("mult_hi", 64'(HI), 64'hFFFF_FFFF);
        check("mult_lo", 64'(LO), 64'hFFFF_FFFA);
        run_op("multu_len", OP_MULTU, 32'hFFFF_FFFE, 32'd3, MC);
        check("multu_hi", 64'(HI), 64'h0000_0002);
        check("multu_lo", 64'(LO), 64'hFFFF_FFFA);

        // Divide
        run_op("div_len", OP_DIV, 32'hFFFF_FFF9, 32'd2, DC);
        check("div_lo", 64'(LO), 64'hFFFF_FFFD);
        check("div_hi", 64'(HI), 64'hFFFF_FFFF);
        run_op("divu_len", OP_DIVU, 32'd7, 32'd2, DC);
        check("divu_lo", 64'(LO), 64'd3);
        check("divu_hi", 64'(HI), 64'd1);

        // Divide by zero keeps HI/LO; most-negative over -1
        cyc(1'b1, OP_MTHI, 32'h0000_00AA, 0, 1'b0);
        cyc(1'b1, OP_MTLO, 32'h0000_00BB, 0, 1'b0);
        run_op("div0_len", OP_DIVU, 32'd7, 32'd0, DC);
        check("div0_hi", 64'(HI), 64'hAA);
        check("div0_lo", 64'(LO), 64'hBB);
        run_op("divovf_len", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DC);
        check("divovf_lo", 64'(LO), 64'h8000_0000);
        check("divovf_hi", 64'(HI), 64'h0);

        // MTHI while busy is ignored; accepted once Busy is sampled low
        begin
            int guard;
            guard = 0;
            cyc(1'b1, OP_MULT, 32'd2, 32'd3, 1'b0);
            idle();
            cyc(1'b1, OP_MTHI, 32'h55, 0, 1'b0);
            while (Busy && guard < 50) begin
                guard++;
                idle();
            end
            check("busy_ign_hi", 64'(HI), 64'h0);
            check("busy_ign_lo", 64'(LO), 64'h6);
            cyc(1'b1, OP_MTHI, 32'h77, 0, 1'b0);
            check("accept_hi", 64'(HI), 64'h77);
        end

        // Flush on the final count cycle together with Start
        cyc(1'b1, OP_MTHI, 32'h11, 0, 1'b0);
        cyc(1'b1, OP_MTLO, 32'h22, 0, 1'b0);
        cyc(1'b1, OP_MULT, 32'd5, 32'd5, 1'b0);
        repeat (MC - 1) idle();
        cyc(1'b1, OP_MTHI, 32'h99, 0, 1'b1);
        check("flush_busy", 64'(Busy), 64'(0));
        check("flush_hi", 64'(HI), 64'h11);
        check("flush_lo", 64'(LO), 64'h22);
        idle();
        check("flush_after_busy", 64'(Busy), 64'(0));
        check("flush_after_hi", 64'(HI), 64'h11);

        // Flush with Busy low blocks MTLO
        cyc(1'b1, OP_MTLO, 32'h33, 0, 1'b1);
        check("idle_flush_lo", 64'(LO), 64'h22);

        // Randomized traffic; operands change freely while busy
        for (int i = 0; i < 4000; i++) begin
            bit          s, f;
            logic [2:0]  op;
            s  = ($urandom_range(0, 99) < 55);
            f  = ($urandom_range(0, 99) < 4);
            op = 3'($urandom_range(0, 7));
            cyc(s, op, rand_word(), rand_word(), f);
            if ($urandom_range(0, 999) < 3) async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
